product_accumulator: RTL and testbench
======================================

# product_accumulator

Downstream consumer of the registered 8x8 multiplier in the dc datapath. Takes the multiplier's 16-bit product stream, which cannot be stalled, and sums fixed-length groups of VEC_LEN products into ACC_W-bit dot-product results. Completed results are buffered in a small FIFO. The FIFO is drained through a valid/ready output handshake toward the router-side consumer.

## Interface
Parameters:
- ACC_W, 24, accumulator/result width; legal range 17..32.
- VEC_LEN, 8, products per result; legal range 2..256.
- FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  single clock; all state on posedge.
- rstn  in  1  asynchronous, active-low reset.
- prod_valid  in  1  prod_i carries a valid product this cycle; no backpressure exists upstream.
- prod_i  in  16  unsigned product, aligned with prod_valid.
- clear  in  1  synchronous discard of the partial accumulation.
- res_valid  out  1  FIFO head is valid.
- res_ready  in  1  consumer accepts the head.
- res_data  out  ACC_W  accumulated result at FIFO head.
- res_ovf  out  1  head result overflowed (wrapped or saturated).
- drop_err  out  1  sticky: a completed result was lost because the FIFO was full.
- grp_cnt  out  8  products accumulated in the current group.

## Operation
- State: acc[ACC_W-1:0], acc_ovf, grp_cnt 0..VEC_LEN-1, FIFO.
- Per accepted product: sum = acc + zero-extended prod_i, computed at ACC_W+1 bits. The carry-out sets the overflow condition.
- Two states:
  - ACCUM: grp_cnt < VEC_LEN-1. On prod_valid, acc ← sum, acc_ovf |= carry, grp_cnt++.
  - On prod_valid with grp_cnt == VEC_LEN-1: push {sum, acc_ovf|carry} into the FIFO. Then acc ← 0, acc_ovf ← 0, grp_cnt ← 0.
- FIFO pop: res_valid && res_ready.
- Full FIFO on push without a simultaneous pop: the result is discarded, drop_err ← 1, and the group counter still wraps to 0.
- Push and pop in the same cycle while full: both proceed; no drop.
- Push and pop in the same cycle while empty: the push lands and res_valid rises the next cycle. There is no fall-through.
- clear: acc, acc_ovf and grp_cnt go to 0 and the FIFO is untouched.
- clear together with prod_valid in the same cycle: clear wins and the product is discarded.
- res_data and res_ovf hold their values while res_valid && !res_ready.
- drop_err clears only on reset.

## Timing
- Reset: acc=0, acc_ovf=0, grp_cnt=0, FIFO empty, res_valid=0, res_data=0, res_ovf=0, drop_err=0.
- Reset asserted mid-group or with a non-empty FIFO: all state is lost immediately and asynchronously.
- Latency: the last product of a group is sampled at edge N, and res_valid/res_data are valid after edge N (one cycle).
- Throughput: one product per cycle sustained. One result per VEC_LEN cycles.
- Outputs are registered FIFO storage, not the adder output, so there is no combinational path from prod_i to res_data.
- No combinational path from res_ready to res_valid.

## Configuration
- SATURATE_EN defined: on carry-out, acc clamps to 2^ACC_W-1 and stays there for the rest of the group. res_ovf=1 for that result.
- SATURATE_EN undefined: arithmetic wraps modulo 2^ACC_W and res_ovf=1 flags the wrap. The saturation mux is not built.

## Structure
- Shared package dc_pkg: PROD_W=16, default ACC_W/VEC_LEN/FIFO_DEPTH constants, and the result struct type {data, ovf}.
- One sub-module, result_fifo:
  - parameterised width/depth, synchronous, registered head;
  - has push/pop/full/empty.
- Accumulator, counter and overflow logic stay in the top module.

## Test plan
- Defaults; 8 consecutive products of 65025, res_ready=1 → one cycle after the 8th, res_valid=1 with res_data=0x07F008 and res_ovf=0. grp_cnt returns to 0.
- ACC_W=17, eight products of 65025:
  - without SATURATE_EN → res_data=126984, res_ovf=1;
  - with SATURATE_EN → res_data=131071, res_ovf=1.
- res_ready=0, five full groups of product 1 → four results of 8 are held, drop_err=1. Releasing res_ready drains exactly four results.
- FIFO full, with a pop and the last product of a group in the same cycle → no drop, drop_err stays 0, and the FIFO stays full with the new result at the tail.
- 5 products of 10, then clear, then 8 products of 3 → the only result is 24. clear asserted with a product in the same cycle drops that product.
- Reset asserted after 3 products with 2 results queued → all outputs 0 immediately. After release, 8 products of 1 yield a result of 8.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared dc datapath package (dc_pkg): product width, default sizing for the
// product accumulator, the result record and the group-phase encoding.
package dc_pkg;

   localparam int PROD_W         = 16;
   localparam int DEF_ACC_W      = 24;
   localparam int DEF_VEC_LEN    = 8;
   localparam int DEF_FIFO_DEPTH = 4;
   localparam int MAX_ACC_W      = 32;

   // One completed dot-product result; data is sized for the widest ACC_W.
   typedef struct packed {
      logic [MAX_ACC_W-1:0] data;
      logic                 ovf;
   } result_t;

   // ACCUM while the group is still filling, LAST when the next product closes it.
   typedef enum logic {
      PH_ACCUM = 1'b0,
      PH_LAST  = 1'b1
   } phase_e;

   // Counter value at which the incoming product completes a group.
   function automatic logic [7:0] last_index(input int vec_len);
      return 8'(vec_len - 1);
   endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product-in / result-out bus of the product accumulator. The master side
// feeds products and consumes results; the slave side is the accumulator.
interface product_accumulator_if #(
   parameter int ACC_W = dc_pkg::DEF_ACC_W
);

   logic                      prod_valid;
   logic [dc_pkg::PROD_W-1:0] prod_i;
   logic                      clear;
   logic                      res_valid;
   logic                      res_ready;
   logic [ACC_W-1:0]          res_data;
   logic                      res_ovf;

   modport master (
      output prod_valid, prod_i, clear, res_ready,
      input  res_valid, res_data, res_ovf
   );

   modport slave (
      input  prod_valid, prod_i, clear, res_ready,
      output res_valid, res_data, res_ovf
   );

endinterface

// File: rtl/product_accumulator_result_fifo.sv
// result_fifo: small synchronous FIFO with the head held in register storage.
// Push is refused when full unless a pop happens in the same cycle; pop is
// ignored when empty. The head reads as zero while the FIFO is empty.
module result_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic [AW:0]      cnt_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign pop_ok  = pop_i && !empty_o;
   // When full, the slot being written is the head that is popped this edge.
   assign push_ok = push_i && (!full_o || pop_ok);
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + AW'(1);
         if (pop_ok)  rd_q <= rd_q + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Result storage; contents are only observed through a valid head.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/product_accumulator.sv
// product_accumulator: sums groups of VEC_LEN unsigned 16-bit products into
// ACC_W-bit results, queues them in result_fifo and drains them over a
// valid/ready handshake. Optional macro SATURATE_EN: clamp the accumulator at
// 2^ACC_W-1 on carry-out instead of wrapping.
module product_accumulator
   import dc_pkg::*;
#(
   parameter int ACC_W      = DEF_ACC_W,
   parameter int VEC_LEN    = DEF_VEC_LEN,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   product_accumulator_if.slave  bus,
   output logic                  drop_err,
   output logic [7:0]            grp_cnt
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             drop_q, drop_d;

   logic [ACC_W:0]   sum;
   logic             carry;
   logic [ACC_W-1:0] acc_nxt;
   phase_e           phase;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [ACC_W:0]   wr_vec;
   logic [ACC_W:0]   head_vec;

   // One extra bit so the carry-out is the overflow flag.
   assign sum   = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, bus.prod_i};
   assign carry = sum[ACC_W];

`ifdef SATURATE_EN
   function automatic logic [ACC_W-1:0] clamp_sum(input logic [ACC_W:0] s);
      return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
   endfunction

   assign acc_nxt = clamp_sum(sum);
`else
   assign acc_nxt = sum[ACC_W-1:0];
`endif

   assign phase  = (cnt_q == last_index(VEC_LEN)) ? PH_LAST : PH_ACCUM;
   assign pop    = !fifo_empty && bus.res_ready;
   // clear beats a product in the same cycle, so it also suppresses the push.
   assign push   = bus.prod_valid && !bus.clear && (phase == PH_LAST);
   assign wr_vec = {ovf_q | carry, acc_nxt};

   // Next accumulator, overflow, group-count and drop-flag values.
   always_comb begin
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      cnt_d  = cnt_q;
      drop_d = drop_q | (push && fifo_full && !pop);
      if (bus.clear) begin
         acc_d = '0;
         ovf_d = 1'b0;
         cnt_d = '0;
      end else if (bus.prod_valid) begin
         if (phase == PH_LAST) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
         end else begin
            acc_d = acc_nxt;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Accumulator state with asynchronous reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
         drop_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   result_fifo #(
      .WIDTH (ACC_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (push),
      .data_i  (wr_vec),
      .pop_i   (pop),
      .data_o  (head_vec),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign bus.res_valid = !fifo_empty;
   assign bus.res_data  = head_vec[ACC_W-1:0];
   assign bus.res_ovf   = head_vec[ACC_W];
   assign drop_err      = drop_q;
   assign grp_cnt       = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: a default-width instance and an ACC_W=17
// instance share the same directed stimulus and are compared every cycle
// against a behavioural model, plus literal checks of hand-computed values.
module tb_product_accumulator;
   import dc_pkg::*;

`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   product_accumulator_if #(.ACC_W(24)) bus0 ();
   product_accumulator_if #(.ACC_W(17)) bus1 ();
   logic       drop0, drop1;
   logic [7:0] grp0, grp1;

   product_accumulator #(.ACC_W(24), .VEC_LEN(8), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .rstn(rstn), .bus(bus0), .drop_err(drop0), .grp_cnt(grp0));
   product_accumulator #(.ACC_W(17), .VEC_LEN(8), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .rstn(rstn), .bus(bus1), .drop_err(drop1), .grp_cnt(grp1));

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input int k, input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL dut%0d %s: got %0d, required %0d", k, nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      longint  acc;
      bit      ovf;
      int      cnt;
      int      n;
      int      hd;
      bit      drop;
      bit      wr;
      int      slot;
      result_t res;
   } mstate_t;

   longint  macc [2];
   bit      movf [2];
   int      mc   [2];
   int      mn   [2];
   int      mhd  [2];
   bit      mdrop[2];
   result_t mbuf [2][4];
   mstate_t ns   [2];

   function automatic longint maxv(input int k);
      return (k == 0) ? 64'hFF_FFFF : 64'h1_FFFF;
   endfunction

   function automatic mstate_t mstep(input int k, input bit v, input logic [15:0] p,
                                     input bit clr, input bit rdy);
      mstate_t st;
      longint  s, a;
      bit      cy;
      st.acc = macc[k]; st.ovf = movf[k]; st.cnt = mc[k];
      st.n = mn[k]; st.hd = mhd[k]; st.drop = mdrop[k];
      st.wr = 1'b0; st.slot = 0; st.res = '0;
      if (st.n > 0 && rdy) begin
         st.hd = (st.hd + 1) % 4;
         st.n  = st.n - 1;
      end
      if (clr) begin
         st.acc = 0; st.ovf = 1'b0; st.cnt = 0;
      end else if (v) begin
         s  = st.acc + longint'(p);
         cy = (s > maxv(k));
         a  = !cy ? s : (SAT ? maxv(k) : s - maxv(k) - 1);
         st.ovf = st.ovf | cy;
         if (st.cnt == 7) begin
            if (st.n == 4) st.drop = 1'b1;
            else begin
               st.wr = 1'b1;
               st.slot = (st.hd + st.n) % 4;
               st.res.data = 32'(a);
               st.res.ovf = st.ovf;
               st.n = st.n + 1;
            end
            st.acc = 0; st.ovf = 1'b0; st.cnt = 0;
         end else begin
            st.acc = a;
            st.cnt = st.cnt + 1;
         end
      end
      return st;
   endfunction

   always_comb begin
      for (int k = 0; k < 2; k++)
         ns[k] = mstep(k, bus0.prod_valid, bus0.prod_i, bus0.clear, bus0.res_ready);
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < 2; k++) begin
            macc[k] <= 0; movf[k] <= 1'b0; mc[k] <= 0;
            mn[k] <= 0; mhd[k] <= 0; mdrop[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            macc[k]  <= ns[k].acc;
            movf[k]  <= ns[k].ovf;
            mc[k]    <= ns[k].cnt;
            mn[k]    <= ns[k].n;
            mhd[k]   <= ns[k].hd;
            mdrop[k] <= ns[k].drop;
            if (ns[k].wr) mbuf[k][ns[k].slot] <= ns[k].res;
         end
      end
   end

   task automatic cmp_dut(input int k);
      logic [63:0] v, d, o, dr, g;
      if (k == 0) begin
         v = 64'(bus0.res_valid); d = 64'(bus0.res_data); o = 64'(bus0.res_ovf);
         dr = 64'(drop0); g = 64'(grp0);
      end else begin
         v = 64'(bus1.res_valid); d = 64'(bus1.res_data); o = 64'(bus1.res_ovf);
         dr = 64'(drop1); g = 64'(grp1);
      end
      check(k, "res_valid", v, 64'(mn[k] > 0));
      if (mn[k] > 0) begin
         check(k, "res_data", d, 64'(mbuf[k][mhd[k]].data));
         check(k, "res_ovf", o, 64'(mbuf[k][mhd[k]].ovf));
      end
      check(k, "drop_err", dr, 64'(mdrop[k]));
      check(k, "grp_cnt", g, 64'(mc[k]));
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         cmp_dut(0);
         cmp_dut(1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input bit v, input logic [15:0] p, input bit clr, input bit rdy);
      bus0.prod_valid = v; bus0.prod_i = p; bus0.clear = clr; bus0.res_ready = rdy;
      bus1.prod_valid = v; bus1.prod_i = p; bus1.clear = clr; bus1.res_ready = rdy;
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus0.prod_valid = 1'b0; bus0.prod_i = '0; bus0.clear = 1'b0; bus0.res_ready = 1'b0;
      bus1.prod_valid = 1'b0; bus1.prod_i = '0; bus1.clear = 1'b0; bus1.res_ready = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int cnt;
      int got[$];
      do_reset();
      @(negedge clk);
      check(0, "rst_valid", 64'(bus0.res_valid), 0);
      check(0, "rst_data", 64'(bus0.res_data), 0);
      check(0, "rst_drop", 64'(drop0), 0);
      check(0, "rst_grp", 64'(grp0), 0);

      // Eight products of 65025: 520200 fits in 24 bits, overflows 17 bits.
      repeat (8) cyc(1'b1, 16'd65025, 1'b0, 1'b1);
      check(0, "t1_valid", 64'(bus0.res_valid), 1);
      check(0, "t1_data", 64'(bus0.res_data), 64'h07F008);
      check(0, "t1_ovf", 64'(bus0.res_ovf), 0);
      check(0, "t1_grp", 64'(grp0), 0);
      check(1, "t1_data17", 64'(bus1.res_data), SAT ? 64'd131071 : 64'd126984);
      check(1, "t1_ovf17", 64'(bus1.res_ovf), 1);
      cyc(1'b0, 16'd0, 1'b0, 1'b1);
      check(0, "t1_popped", 64'(bus0.res_valid), 0);

      // Five groups of 1 with the consumer stalled: fifth result is dropped.
      repeat (40) cyc(1'b1, 16'd1, 1'b0, 1'b0);
      check(0, "t2_drop", 64'(drop0), 1);
      check(0, "t2_head", 64'(bus0.res_data), 8);
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (bus0.res_valid) cnt++;
         cyc(1'b0, 16'd0, 1'b0, 1'b1);
      end
      check(0, "t2_drained", 64'(cnt), 4);

      // Full FIFO, pop coincides with the last product of a group.
      do_reset();
      repeat (32) cyc(1'b1, 16'd1, 1'b0, 1'b0);
      repeat (7) cyc(1'b1, 16'd2, 1'b0, 1'b0);
      cyc(1'b1, 16'd2, 1'b0, 1'b1);
      check(0, "t3_nodrop", 64'(drop0), 0);
      got.delete();
      for (int i = 0; i < 8; i++) begin
         if (bus0.res_valid) got.push_back(int'(bus0.res_data));
         cyc(1'b0, 16'd0, 1'b0, 1'b1);
      end
      check(0, "t3_count", 64'(got.size()), 4);
      if (got.size() == 4) begin
         check(0, "t3_first", 64'(got[0]), 8);
         check(0, "t3_tail", 64'(got[3]), 16);
      end

      // clear discards the partial sum and a coincident product.
      do_reset();
      repeat (5) cyc(1'b1, 16'd10, 1'b0, 1'b0);
      cyc(1'b1, 16'd99, 1'b1, 1'b0);
      check(0, "t4_grp", 64'(grp0), 0);
      repeat (8) cyc(1'b1, 16'd3, 1'b0, 1'b0);
      check(0, "t4_valid", 64'(bus0.res_valid), 1);
      check(0, "t4_data", 64'(bus0.res_data), 24);
      cyc(1'b0, 16'd0, 1'b0, 1'b1);
      check(0, "t4_only", 64'(bus0.res_valid), 0);

      // Asynchronous reset mid-group with two queued results.
      do_reset();
      repeat (19) cyc(1'b1, 16'd1, 1'b0, 1'b0);
      check(0, "t5_grp", 64'(grp0), 3);
      check(0, "t5_valid", 64'(bus0.res_valid), 1);
      #2 rstn = 1'b0;
      #1;
      check(0, "t5_rvalid", 64'(bus0.res_valid), 0);
      check(0, "t5_rdata", 64'(bus0.res_data), 0);
      check(0, "t5_rovf", 64'(bus0.res_ovf), 0);
      check(0, "t5_rgrp", 64'(grp0), 0);
      check(1, "t5_rvalid17", 64'(bus1.res_valid), 0);
      bus0.prod_valid = 1'b0; bus1.prod_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      repeat (8) cyc(1'b1, 16'd1, 1'b0, 1'b1);
      check(0, "t5_after_valid", 64'(bus0.res_valid), 1);
      check(0, "t5_after_data", 64'(bus0.res_data), 8);
      cyc(1'b0, 16'd0, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
